// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one ripple-carry adder between NUM_REQ requesters.
// One registered, ID-tagged response slot; full throughput while downstream is ready.
module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [31:0]              op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_sum_q;
    logic               rsp_cout_q;
    logic [31:0]        op_count_q;

    logic               accept_en;
    logic               handshake;
    logic               xfer;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_id;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               cin_sel;
    logic [WIDTH-1:0]   rsp_sum_d;
    logic               rsp_cout_d;

    assign rsp_valid = (state_q == HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign op_count  = op_count_q;

    assign handshake = rsp_valid & rsp_ready;
    assign accept_en = (state_q == IDLE) | handshake;
    assign req_ready = (accept_en && !rst) ? grant_oh : '0;
    assign xfer      = |req_ready;

    // Scan from ptr upward, wrapping; the first valid index wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_oh = '0;
        found    = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req_valid[i]) begin
                    found       = 1'b1;
                    grant_oh[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_id = '0;
        a_sel    = '0;
        b_sel    = '0;
        cin_sel  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_id = ID_W'(i);
                a_sel    = req_a[i*WIDTH +: WIDTH];
                b_sel    = req_b[i*WIDTH +: WIDTH];
                cin_sel  = req_cin[i];
            end
        end
    end

    always_comb begin
        if (32'(grant_id) == NUM_REQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_id + 1'b1;
        end
    end

    // Shared ripple-carry adder datapath.
    always_comb begin
        logic carry;
        carry     = cin_sel;
        rsp_sum_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rsp_sum_d[i] = a_sel[i] ^ b_sel[i] ^ carry;
            carry        = (a_sel[i] & b_sel[i]) | (carry & (a_sel[i] ^ b_sel[i]));
        end
        rsp_cout_d = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            if (handshake) begin
                op_count_q <= op_count_q + 32'd1;
            end
            if (xfer) begin
                state_q    <= HOLD;
                rsp_id_q   <= grant_id;
                rsp_sum_q  <= rsp_sum_d;
                rsp_cout_q <= rsp_cout_d;
                ptr_q      <= ptr_d;
            end else if (handshake) begin
                state_q <= IDLE;
            end
        end
    end

endmodule
